// File: rtl/alu_mult_seq.sv
// rtl/alu_mult_seq.sv - Shift-add 32x32->64 multiply sequencer that drives the shared ALU.
package alu_mult_seq_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module alu_mult_seq
  import alu_mult_seq_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output aluop_t      alu_op,
  output logic [31:0] alu_portA,
  output logic [31:0] alu_portB,
  input  logic [31:0] alu_portOut
);

  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    MUL    = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        mcand_q, mcand_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               sgn_q, sgn_d;
  logic               z_q, z_d;
  logic               carry;

  // Carry-out of hi+mcand rebuilt from the operand and sum MSBs, since the ALU exposes no carry.
  assign carry = (hi_q[31] & mcand_q[31]) |
                 ((hi_q[31] | mcand_q[31]) & ~alu_portOut[31]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    sgn_d     = sgn_q;
    z_d       = z_q;
    alu_op    = ALU_ADD;
    alu_portA = '0;
    alu_portB = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          sgn_d   = signed_op;
          neg_d   = signed_op & (a[31] ^ b[31]);
          state_d = signed_op ? ABS_A : MUL;
        end
      end

      ABS_A: begin
        alu_op    = ALU_SUB;
        alu_portB = mcand_q;
        if (mcand_q[31]) mcand_d = alu_portOut;
        state_d   = ABS_B;
      end

      ABS_B: begin
        alu_op    = ALU_SUB;
        alu_portB = lo_q;
        if (lo_q[31]) lo_d = alu_portOut;
        state_d   = MUL;
      end

      MUL: begin
        alu_op    = ALU_ADD;
        alu_portA = hi_q;
        alu_portB = mcand_q;
        if (lo_q[0]) begin
          hi_d = {carry, alu_portOut[31:1]};
          lo_d = {alu_portOut[0], lo_q[31:1]};
        end else begin
          hi_d = {1'b0, hi_q[31:1]};
          lo_d = {hi_q[0], lo_q[31:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = sgn_q ? FIX_LO : DONE;
      end

      // 64-bit negate as two halves: lo = -lo, hi = ~hi + (lo was zero).
      FIX_LO: begin
        alu_op    = ALU_SUB;
        alu_portB = lo_q;
        if (neg_q) begin
          lo_d = alu_portOut;
          z_d  = (lo_q == 32'd0);
        end
        state_d = FIX_HI;
      end

      FIX_HI: begin
        alu_op    = ALU_ADD;
        alu_portA = ~hi_q;
        alu_portB = {31'b0, z_q};
        if (neg_q) hi_d = alu_portOut;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == ABS_A) || (state_q == ABS_B) || (state_q == MUL) ||
                (state_q == FIX_LO) || (state_q == FIX_HI);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb/tb_alu_mult_seq.sv - Randomized self-checking bench for alu_mult_seq against a product model.
module tb_alu_mult_seq;
  import alu_mult_seq_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  aluop_t      alu_op;
  logic [31:0] alu_portA;
  logic [31:0] alu_portB;
  logic [31:0] alu_portOut;

  int vectors = 0;
  int miscompares = 0;

  alu_mult_seq #(.ITERS(32)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_op(alu_op), .alu_portA(alu_portA), .alu_portB(alu_portB),
    .alu_portOut(alu_portOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared ALU stand-in
  always_comb begin
    alu_portOut = 32'd0;
    if (alu_op == ALU_ADD) alu_portOut = alu_portA + alu_portB;
    else if (alu_op == ALU_SUB) alu_portOut = alu_portA - alu_portB;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic [63:0] ux;
    logic [63:0] uy;
    longint      sp;
    if (s) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      return 64'(sp);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Protocol monitor on the ALU master side
  always @(negedge CLK) begin
    chk("alu_op_legal", 64'((alu_op == ALU_ADD) || (alu_op == ALU_SUB)), 64'd1);
    if (!busy) begin
      chk("idle_alu_op", 64'(alu_op), 64'(ALU_ADD));
      chk("idle_alu_ports", {alu_portA, alu_portB}, 64'd0);
    end
  end

  logic [63:0] last_exp;

  // Starts an op in cycle 0; inj1/inj2 name cycles in which a stray start is pulsed.
  task automatic run_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic sgn,
                        input int inj1, input int inj2);
    int  lat;
    int  busy_cnt;
    int  add_cnt;
    bit  got;
    @(negedge CLK);
    a         = a_v;
    b         = b_v;
    signed_op = sgn;
    start     = 1'b1;
    last_exp  = ref_mul(a_v, b_v, sgn);
    lat       = sgn ? 37 : 33;
    busy_cnt  = 0;
    add_cnt   = 0;
    got       = 0;
    for (int c = 1; c <= lat + 8 && !got; c++) begin
      @(negedge CLK);
      start = (c == inj1) || (c == inj2);
      if (start) begin
        a         = $urandom;
        b         = $urandom;
        signed_op = 1'($urandom);
      end
      if (c == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (done) begin
        got = 1;
        chk("latency", 64'(c), 64'(lat));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("product", {hi, lo}, last_exp);
      end else if (busy) begin
        busy_cnt++;
        if (alu_op == ALU_ADD) add_cnt++;
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    chk("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
    chk("add_cycles", 64'(add_cnt), sgn ? 64'd33 : 64'd32);
  endtask

  initial begin
    nRST      = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    nRST = 1'b1;

    run_op(32'd7, 32'd6, 1'b0, -1, -1);
    chk("u7x6", {hi, lo}, 64'h0000_0000_0000_002A);
    @(negedge CLK);
    chk("hold_after_done", {hi, lo}, 64'h0000_0000_0000_002A);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1);
    chk("uffxff", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, -1, -1);
    chk("s_m3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, -1, -1);
    chk("s_m4xm4", {hi, lo}, 64'h0000_0000_0000_0010);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, -1);
    chk("s_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(32'h8000_0000, 32'd1, 1'b1, -1, -1);
    chk("s_minx1", {hi, lo}, 64'hFFFF_FFFF_8000_0000);

    // Stray starts at cycles 5 and 33 are ignored; the next op starts in cycle 34.
    run_op(32'h1234_5678, 32'h0BAD_F00D, 1'b0, 5, 33);
    run_op(32'd9, 32'hFFFF_FFF7, 1'b1, -1, -1);

    // Asynchronous reset in cycle 15 of a signed op
    @(negedge CLK);
    a = 32'hFFFF_FFFD; b = 32'd5; signed_op = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (14) @(negedge CLK);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2 nRST = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge CLK);
    chk("abort_no_done", 64'(done), 64'd0);
    nRST = 1'b1;
    run_op(32'd2, 32'd3, 1'b0, -1, -1);
    chk("after_reset", {hi, lo}, 64'd6);

    for (int i = 0; i < 12; i++) begin
      run_op(pick(), pick(), 1'($urandom), -1, -1);
    end

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
